tt_um_ternary_mac: RTL and testbench

TT_UM_TERNARY_MAC -- requirements
Module: tt_um_ternary_mac

---
 rtl/tt_ternary_pkg.sv | 22 ++
 rtl/tt_ternary_col.sv | 46 ++++
 rtl/tt_um_ternary_mac.sv | 151 +++++++++++++++
 tb/tb_tt_um_ternary_mac.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_ternary_pkg.sv
// Shared definitions for the ternary-weight MAC: weight codes, FSM states
// and index widths fixed by the 7-bit ui_param encoding.
package tt_ternary_pkg;

    localparam int ACC_W_DEFAULT = 16;

    // Index widths follow ui_param: [6:3] = in_len-1, [2:0] = out_len-1.
    localparam int ROW_W = 4;
    localparam int COL_W = 3;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        OUT_MSB = 2'd2,
        OUT_LSB = 2'd3
    } state_t;

endpackage

// File: rtl/tt_ternary_col.sv
// One output column: ternary weight decode, then load / accumulate / hold
// of a signed ACC_W-bit running sum.
module tt_ternary_col
    import tt_ternary_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             add,
    input  logic [7:0]       x,
    input  logic [1:0]       w,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] x_ext;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] acc_reg;

    assign x_ext = {{(ACC_W-8){x[7]}}, x};

    // 2'b10 is an unused code and decodes to zero like W_ZERO.
    always_comb begin
        case (w)
            W_POS:   term = x_ext;
            W_NEG:   term = '0 - x_ext;
            W_ZERO:  term = '0;
            default: term = '0;
        endcase
    end

    // load replaces the sum so a new vector never inherits a stale total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (load) begin
            acc_reg <= term;
        end else if (add) begin
            acc_reg <= acc_reg + term;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/tt_um_ternary_mac.sv
// Ternary-weight matrix-vector MAC: streams activations in, accumulates all
// columns in parallel, then emits each column's sum as MSB/LSB byte pairs.
module tt_um_ternary_mac
    import tt_ternary_pkg::*;
#(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int ACC_W       = ACC_W_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    input  logic [7:0]                         ui_input,
    input  logic [6:0]                         ui_param,
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
    output logic [7:0]                         uo_output,
    output logic                               uo_valid,
    output logic                               uo_busy
);

    localparam int ROWS    = 1 << ROW_W;
    localparam int COLS    = 1 << COL_W;
    localparam int ROW_BITS = 2 * MAX_OUT_LEN;

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [COL_W-1:0]   out_last_reg, out_last_next;

    logic [ROW_W-1:0]   in_last;
    logic [ROW_W-1:0]   row_sel;
    logic [ROW_BITS-1:0] row_w;
    logic               col_load;
    logic               col_add;
    logic [ACC_W-1:0]   acc_sel;

    logic [ROW_BITS-1:0] weight_rows [ROWS];
    logic [ACC_W-1:0]    acc_cols    [COLS];

    assign in_last  = ui_param[6:3];
    assign col_load = (state_reg == IDLE)  && ena;
    assign col_add  = (state_reg == ACCUM) && ena;

    // Rows are padded to the full index range so row_reg never indexes out of bounds.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            if (gi < MAX_IN_LEN) begin : g_used
                assign weight_rows[gi] = ui_weights[ROW_BITS*gi +: ROW_BITS];
            end else begin : g_pad
                assign weight_rows[gi] = '0;
            end
        end
    endgenerate

    // The first activation of a vector always uses row 0, whatever row_reg holds.
    assign row_sel = (state_reg == IDLE) ? '0 : row_reg;
    assign row_w   = weight_rows[row_sel];

    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            if (gi < MAX_OUT_LEN) begin : g_used
                tt_ternary_col #(
                    .ACC_W (ACC_W)
                ) u_col (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .load  (col_load),
                    .add   (col_add),
                    .x     (ui_input),
                    .w     (row_w[2*gi +: 2]),
                    .acc   (acc_cols[gi])
                );
            end else begin : g_pad
                assign acc_cols[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        out_last_next = out_last_reg;
        case (state_reg)
            IDLE: begin
                if (ena) begin
                    row_next      = {{(ROW_W-1){1'b0}}, 1'b1};
                    col_next      = '0;
                    out_last_next = ui_param[2:0];
                    state_next    = (in_last == '0) ? OUT_MSB : ACCUM;
                end
            end
            ACCUM: begin
                if (ena) begin
                    out_last_next = ui_param[2:0];
                    if (row_reg == in_last) begin
                        row_next   = '0;
                        col_next   = '0;
                        state_next = OUT_MSB;
                    end else begin
                        row_next = row_reg + 1'b1;
                    end
                end
            end
            OUT_MSB: begin
                state_next = OUT_LSB;
            end
            OUT_LSB: begin
                if (col_reg == out_last_reg) begin
                    col_next   = '0;
                    state_next = IDLE;
                end else begin
                    col_next   = col_reg + 1'b1;
                    state_next = OUT_MSB;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            out_last_reg <= '0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            out_last_reg <= out_last_next;
        end
    end

    // Outputs decode purely from registers, so reset clears them at once.
    assign acc_sel  = acc_cols[col_reg];
    assign uo_valid = (state_reg == OUT_MSB) || (state_reg == OUT_LSB);
    assign uo_busy  = (state_reg != IDLE);

    always_comb begin
        case (state_reg)
            OUT_MSB: uo_output = acc_sel[15:8];
            OUT_LSB: uo_output = acc_sel[7:0];
            default: uo_output = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
// Scoreboard bench for tt_um_ternary_mac: directed vectors push expected
// bytes, a negedge monitor pops and compares every valid output byte.
module tb_tt_um_ternary_mac;

    localparam int MAX_IN  = 16;
    localparam int MAX_OUT = 8;
    localparam int WBITS   = 2 * MAX_IN * MAX_OUT;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic [7:0]       ui_input;
    logic [6:0]       ui_param;
    logic [WBITS-1:0] ui_weights;
    logic [7:0]       uo_output;
    logic             uo_valid;
    logic             uo_busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    tt_um_ternary_mac #(
        .MAX_IN_LEN  (MAX_IN),
        .MAX_OUT_LEN (MAX_OUT),
        .ACC_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ui_input   (ui_input),
        .ui_param   (ui_param),
        .ui_weights (ui_weights),
        .uo_output  (uo_output),
        .uo_valid   (uo_valid),
        .uo_busy    (uo_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (uo_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected got=%02h expected=none", uo_output);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb.pop_front();
                if (uo_output !== exp_b) begin
                    errors++;
                    $display("FAIL byte got=%02h expected=%02h", uo_output, exp_b);
                end else begin
                    $display("byte %02h ok", uo_output);
                end
            end
        end
    end

    task automatic check1(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h", name, got, want);
        end else begin
            $display("check %s = %02h ok", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] x);
        ena      = 1'b1;
        ui_input = x;
        step();
    endtask

    task automatic set_w(input int i, input int j, input logic [1:0] code);
        ui_weights[2*(i*MAX_OUT+j) +: 2] = code;
    endtask

    task automatic push2(input logic [15:0] v);
        sb.push_back(v[15:8]);
        sb.push_back(v[7:0]);
    endtask

    // Bounded wait for return to IDLE, then confirm the scoreboard drained.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (uo_busy && n < 200) begin
            step();
            n++;
        end
        check1({name, "_busy_end"}, {7'd0, uo_busy}, 8'd0);
        check1({name, "_valid_end"}, {7'd0, uo_valid}, 8'd0);
        check1({name, "_out_idle"}, uo_output, 8'h00);
        check1({name, "_sb_left"}, sb.size()[7:0], 8'd0);
        sb.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b0;
        ui_input   = '0;
        ui_param   = '0;
        ui_weights = '0;
        #3;
        check1("rst_valid", {7'd0, uo_valid}, 8'd0);
        check1("rst_busy", {7'd0, uo_busy}, 8'd0);
        check1("rst_out", uo_output, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1x1, x=5 -> 0x0005
        ui_param = 7'h00;
        set_w(0, 0, 2'b01);
        push2(16'h0005);
        feed(8'd5);
        ena = 1'b0;
        check1("t1_latency_valid", {7'd0, uo_valid}, 8'd1);
        wait_idle("t1");

        // 16x8 all -1, x=-128 -> 2048 per column
        ui_weights = '1;
        ui_param   = 7'h7F;
        for (int j = 0; j < 8; j++) push2(16'h0800);
        for (int i = 0; i < 16; i++) feed(8'h80);
        ena = 1'b0;
        wait_idle("t2");

        // 2x2: col0 (+1,-1), col1 (10,10); x=10,3 -> 7, 0
        ui_weights = '0;
        ui_param   = 7'h09;
        set_w(0, 0, 2'b01); set_w(1, 0, 2'b11);
        set_w(0, 1, 2'b10); set_w(1, 1, 2'b10);
        push2(16'h0007); push2(16'h0000);
        feed(8'd10); feed(8'd3);
        ena = 1'b0;
        wait_idle("t3");

        // 4x2: col0 (+,-,+,+), col1 all -; x=7,2,-3,20 -> 22, -26
        ui_weights = '0;
        ui_param   = 7'h19;
        set_w(0, 0, 2'b01); set_w(1, 0, 2'b11); set_w(2, 0, 2'b01); set_w(3, 0, 2'b01);
        for (int i = 0; i < 4; i++) set_w(i, 1, 2'b11);
        push2(16'h0016); push2(16'hFFE6);
        feed(8'd7); feed(8'd2); feed(8'hFD); feed(8'd20);
        ena = 1'b0;
        wait_idle("t4_nostall");

        push2(16'h0016); push2(16'hFFE6);
        feed(8'd7); feed(8'd2);
        ena = 1'b0;
        ui_input = 8'd99;
        for (int s = 0; s < 3; s++) begin
            step();
            check1("t4_stall_busy", {7'd0, uo_busy}, 8'd1);
            check1("t4_stall_valid", {7'd0, uo_valid}, 8'd0);
        end
        feed(8'hFD); feed(8'd20);
        ena = 1'b0;
        wait_idle("t4_stall");

        // Reset during OUT_LSB drops outputs without a clock edge
        ui_weights = '0;
        ui_param   = 7'h00;
        set_w(0, 0, 2'b01);
        sb.push_back(8'h00);
        feed(8'd9);
        ena = 1'b0;
        step();
        check1("t5_in_lsb_valid", {7'd0, uo_valid}, 8'd1);
        rst_n = 1'b0;
        #1;
        check1("t5_rst_valid", {7'd0, uo_valid}, 8'd0);
        check1("t5_rst_busy", {7'd0, uo_busy}, 8'd0);
        check1("t5_rst_out", uo_output, 8'h00);
        #1;
        rst_n = 1'b1;
        check1("t5_sb_left", sb.size()[7:0], 8'd0);
        sb.delete();
        step();
        push2(16'h0001);
        feed(8'd1);
        ena = 1'b0;
        wait_idle("t5_after");

        // ena held through burst: ignored, then restarts on first IDLE cycle
        ui_weights = '0;
        ui_param   = 7'h01;
        set_w(0, 0, 2'b01); set_w(0, 1, 2'b11);
        push2(16'h0004); push2(16'hFFFC);
        push2(16'h0006); push2(16'hFFFA);
        feed(8'd4);
        ui_input = 8'd99;
        for (int s = 0; s < 4; s++) begin
            check1("t6_burst_busy", {7'd0, uo_busy}, 8'd1);
            step();
        end
        check1("t6_idle_busy", {7'd0, uo_busy}, 8'd0);
        feed(8'd6);
        ena = 1'b0;
        check1("t6_restart_valid", {7'd0, uo_valid}, 8'd1);
        wait_idle("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
